prog_encoder: RTL and testbench

- Inverse of the opcode class decoder. Accepts instruction requests (class plus fields) over a valid/ready handshake and packs each into an 8-bit opcode byte.
- Writes the bytes sequentially into program memory through a write port with backpressure.
- Used by the loader/self-programming path to build programs that the class decoder later consumes.
- Opcode format: bits[7:6] carry the class: 00 immediate, 01 calculate, 10 copy, 11 condition.

---
 rtl/prog_encoder_pkg.sv | 25 ++
 rtl/prog_encoder_if.sv | 24 ++
 rtl/prog_encoder_pack.sv | 40 ++++
 rtl/prog_encoder.sv | 123 ++++++++++++
 tb/tb_prog_encoder.sv | 309 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/prog_encoder_pkg.sv
// Opcode field definitions shared by the program encoder and any future assembler.
package opcode_pkg;

    localparam logic [1:0] CLS_IMM  = 2'b00;
    localparam logic [1:0] CLS_CAL  = 2'b01;
    localparam logic [1:0] CLS_COPY = 2'b10;
    localparam logic [1:0] CLS_COND = 2'b11;

    localparam logic [2:0] ALU_OR     = 3'd0;
    localparam logic [2:0] ALU_NAND   = 3'd1;
    localparam logic [2:0] ALU_NOR    = 3'd2;
    localparam logic [2:0] ALU_AND    = 3'd3;
    localparam logic [2:0] ALU_ADD    = 3'd4;
    localparam logic [2:0] ALU_SUB    = 3'd5;
    localparam logic [2:0] ALU_OP_MAX = 3'd5;

    localparam logic [2:0] REG_IO = 3'd6;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_FULL = 2'b10
    } state_t;

endpackage

// File: rtl/prog_encoder_if.sv
// Request handshake and program-memory write port of the program encoder.
interface prog_encoder_if #(
    parameter int ADDR_W = 8
);
    logic              in_valid;
    logic              in_ready;
    logic [1:0]        in_class;
    logic [5:0]        in_field_a;
    logic [2:0]        in_field_b;
    logic              mem_wr_en;
    logic [ADDR_W-1:0] mem_wr_addr;
    logic [7:0]        mem_wr_data;
    logic              mem_ready;

    modport slave (
        input  in_valid, in_class, in_field_a, in_field_b, mem_ready,
        output in_ready, mem_wr_en, mem_wr_addr, mem_wr_data
    );

    modport master (
        output in_valid, in_class, in_field_a, in_field_b, mem_ready,
        input  in_ready, mem_wr_en, mem_wr_addr, mem_wr_data
    );
endinterface

// File: rtl/prog_encoder_pack.sv
// Purely combinational packing of an instruction class and its fields into an opcode byte.
module opcode_pack
    import opcode_pkg::*;
(
    input  logic [1:0] op_class,
    input  logic [5:0] field_a,
    input  logic [2:0] field_b,
    output logic [7:0] op_byte,
    output logic       legal
);

    // Class-dependent bit packing; register 7 and ALU ops 6/7 do not exist
    always_comb begin
        op_byte = 8'h00;
        legal   = 1'b0;
        case (op_class)
            CLS_IMM: begin
                op_byte = {CLS_IMM, field_a};
                legal   = 1'b1;
            end
            CLS_CAL: begin
                op_byte = {CLS_CAL, 3'b000, field_b};
                legal   = (field_b <= ALU_OP_MAX);
            end
            CLS_COPY: begin
                op_byte = {CLS_COPY, field_a[2:0], field_b};
                legal   = (field_a[2:0] <= REG_IO) && (field_b <= REG_IO);
            end
            CLS_COND: begin
                op_byte = {CLS_COND, 3'b000, field_b};
                legal   = 1'b1;
            end
            default: begin
                op_byte = 8'h00;
                legal   = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/prog_encoder.sv
// Session-based program writer: packs accepted requests into opcodes and streams them to memory.
module prog_encoder
    import opcode_pkg::*;
#(
    parameter int ADDR_W    = 8,
    parameter int DEPTH     = 256,
    parameter int BASE_ADDR = 0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            finish,
    prog_encoder_if.slave   bus,
    output logic [ADDR_W:0] count,
    output logic            busy,
    output logic            full,
    output logic            done,
    output logic            err_range
);

    localparam int                CW      = ADDR_W + 1;
    localparam logic [CW-1:0]     DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0]     ONE_C   = CW'(1);
    localparam logic [ADDR_W-1:0] BASE_C  = ADDR_W'(BASE_ADDR);

    state_t            state_r;
    state_t            state_s;
    logic [CW-1:0]     count_r;
    logic [ADDR_W-1:0] addr_r;
    logic [7:0]        data_r;
    logic              wr_en_r;
    logic              done_r;
    logic              err_r;
    logic [7:0]        pack_byte_s;
    logic              pack_legal_s;
    logic [CW-1:0]     occupancy_s;
    logic              ready_s;
    logic              accept_s;
    logic              commit_s;
    logic              leave_s;

    opcode_pack u_pack (
        .op_class (bus.in_class),
        .field_a  (bus.in_field_a),
        .field_b  (bus.in_field_b),
        .op_byte  (pack_byte_s),
        .legal    (pack_legal_s)
    );

    // The pending byte counts against DEPTH so a session never over-writes
    assign occupancy_s = count_r + {{(CW-1){1'b0}}, wr_en_r};
    assign ready_s     = (state_r == ST_RUN) && (!wr_en_r || bus.mem_ready) && (occupancy_s < DEPTH_C);
    assign accept_s    = bus.in_valid && ready_s;
    assign commit_s    = wr_en_r && bus.mem_ready;
    assign leave_s     = finish && !start && (state_r != ST_IDLE);

    // Next-state selection; start has priority over finish
    always_comb begin
        state_s = state_r;
        if (start) begin
            state_s = ST_RUN;
        end else if (leave_s) begin
            state_s = ST_IDLE;
        end else if ((state_r == ST_RUN) && commit_s && ((count_r + ONE_C) == DEPTH_C)) begin
            state_s = ST_FULL;
        end else begin
            state_s = state_r;
        end
    end

    // Session state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // One-entry output stage plus session counters and flags
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_en_r <= 1'b0;
            addr_r  <= BASE_C;
            data_r  <= 8'h00;
            count_r <= '0;
            err_r   <= 1'b0;
            done_r  <= 1'b0;
        end else if (start) begin
            wr_en_r <= 1'b0;
            addr_r  <= BASE_C;
            count_r <= '0;
            err_r   <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            done_r <= leave_s;
            if (commit_s) begin
                count_r <= count_r + ONE_C;
                addr_r  <= addr_r + ADDR_W'(1);
            end
            if (accept_s && pack_legal_s) begin
                wr_en_r <= 1'b1;
                data_r  <= pack_byte_s;
            end else if (commit_s) begin
                wr_en_r <= 1'b0;
            end
            if (accept_s && !pack_legal_s) begin
                err_r <= 1'b1;
            end
        end
    end

    assign bus.in_ready    = ready_s;
    assign bus.mem_wr_en   = wr_en_r;
    assign bus.mem_wr_addr = addr_r;
    assign bus.mem_wr_data = data_r;
    assign count           = count_r;
    assign busy            = (state_r != ST_IDLE);
    assign full            = (count_r == DEPTH_C);
    assign done            = done_r;
    assign err_range       = err_r;

endmodule

// File: tb/tb_prog_encoder.sv
// Directed bench for prog_encoder: a default instance and a DEPTH=4 instance based at 0xFE.
module tb_prog_encoder;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] start, finish, valid, mem_rdy;
    logic [1:0] cls [2];
    logic [5:0] fa [2];
    logic [2:0] fb [2];
    logic [8:0] count [2];
    logic [1:0] busy, full, done, err, rdy, wen;
    logic [7:0] waddr [2];
    logic [7:0] wdata [2];
    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int log_q0[$];
    int log_q1[$];

    prog_encoder_if #(.ADDR_W(8)) bus0 ();
    prog_encoder_if #(.ADDR_W(8)) bus1 ();

    assign bus0.in_valid = valid[0];   assign bus1.in_valid = valid[1];
    assign bus0.in_class = cls[0];     assign bus1.in_class = cls[1];
    assign bus0.in_field_a = fa[0];    assign bus1.in_field_a = fa[1];
    assign bus0.in_field_b = fb[0];    assign bus1.in_field_b = fb[1];
    assign bus0.mem_ready = mem_rdy[0]; assign bus1.mem_ready = mem_rdy[1];
    assign rdy[0] = bus0.in_ready;     assign rdy[1] = bus1.in_ready;
    assign wen[0] = bus0.mem_wr_en;    assign wen[1] = bus1.mem_wr_en;
    assign waddr[0] = bus0.mem_wr_addr; assign waddr[1] = bus1.mem_wr_addr;
    assign wdata[0] = bus0.mem_wr_data; assign wdata[1] = bus1.mem_wr_data;

    prog_encoder dut0 (
        .clk(clk), .rst(rst), .start(start[0]), .finish(finish[0]), .bus(bus0),
        .count(count[0]), .busy(busy[0]), .full(full[0]), .done(done[0]), .err_range(err[0])
    );

    prog_encoder #(.ADDR_W(8), .DEPTH(4), .BASE_ADDR(254)) dut1 (
        .clk(clk), .rst(rst), .start(start[1]), .finish(finish[1]), .bus(bus1),
        .count(count[1]), .busy(busy[1]), .full(full[1]), .done(done[1]), .err_range(err[1])
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Reference model: what a session has committed, what byte is waiting, and the flags
    typedef struct packed {
        bit sess; int cnt; bit pend; int data; int addr; bit err; bit done;
    } mst_t;
    mst_t m [2];

    function automatic int dep(input int s);  return (s == 0) ? 256 : 4;   endfunction
    function automatic int base(input int s); return (s == 0) ? 0 : 254;   endfunction

    function automatic int enc(input int c, input int a, input int b);
        if (c == 0) return a;
        if (c == 1) return 64 + b;
        if (c == 2) return 128 + (a % 8) * 8 + b;
        return 192 + b;
    endfunction

    function automatic bit legal(input int c, input int a, input int b);
        if (c == 1) return b < 6;
        if (c == 2) return ((a % 8) < 7) && (b < 7);
        return 1'b1;
    endfunction

    function automatic mst_t m_reset(input int s);
        mst_t n = '0;
        n.addr = base(s);
        return n;
    endfunction

    function automatic bit m_ready(input mst_t x, input bit mr, input int d);
        return x.sess && (x.cnt < d) && (!x.pend || mr) && (x.cnt + int'(x.pend) < d);
    endfunction

    function automatic mst_t m_step(input mst_t x, input int s, input bit st, input bit fi,
                                    input bit v, input int c, input int a, input int b, input bit mr);
        mst_t n = x;
        bit acc = v && m_ready(x, mr, dep(s));
        n.done = 1'b0;
        if (x.pend && mr) begin
            n.cnt = x.cnt + 1; n.addr = (x.addr + 1) % 256; n.pend = 1'b0;
        end
        if (acc) begin
            if (legal(c, a, b)) begin n.pend = 1'b1; n.data = enc(c, a, b); end
            else n.err = 1'b1;
        end
        if (fi && !st && x.sess) begin n.sess = 1'b0; n.done = 1'b1; end
        if (st) begin
            n.sess = 1'b1; n.cnt = 0; n.addr = base(s); n.err = 1'b0; n.pend = 1'b0; n.done = 1'b0;
        end
        return n;
    endfunction

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m[0] <= m_reset(0);
            m[1] <= m_reset(1);
        end else begin
            m[0] <= m_step(m[0], 0, start[0], finish[0], valid[0], cls[0], fa[0], fb[0], mem_rdy[0]);
            m[1] <= m_step(m[1], 1, start[1], finish[1], valid[1], cls[1], fa[1], fb[1], mem_rdy[1]);
        end
    end

    task automatic check(input int s, input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL u%0d %s: got 0x%0h expected 0x%0h", s, name, act, exp);
        end
    endtask

    task automatic cmp(input int s);
        mst_t x = m[s];
        check(s, "in_ready", rdy[s], m_ready(x, mem_rdy[s], dep(s)));
        check(s, "mem_wr_en", wen[s], x.pend);
        check(s, "mem_wr_addr", waddr[s], x.addr);
        check(s, "mem_wr_data", wdata[s], x.data);
        check(s, "count", count[s], x.cnt);
        check(s, "busy", busy[s], x.sess);
        check(s, "full", full[s], x.cnt == dep(s));
        check(s, "done", done[s], x.done);
        check(s, "err_range", err[s], x.err);
    endtask

    always @(negedge clk) begin
        cmp(0);
        cmp(1);
    end

    // Commit log: {cycle, addr, data} of every write that the memory took
    always @(negedge clk) begin
        if (rst) begin
            if (wen[0] && mem_rdy[0]) log_q0.push_back((cyc << 16) | (int'(waddr[0]) << 8) | int'(wdata[0]));
            if (wen[1] && mem_rdy[1]) log_q1.push_back((cyc << 16) | (int'(waddr[1]) << 8) | int'(wdata[1]));
        end
    end

    task automatic tick(); @(posedge clk); #2; endtask
    task automatic pulse_start(input int s);  start[s] = 1'b1;  tick(); start[s] = 1'b0;  endtask
    task automatic pulse_finish(input int s); finish[s] = 1'b1; tick(); finish[s] = 1'b0; endtask

    task automatic send(input int s, input int c, input int a, input int b);
        bit acc = 1'b0;
        valid[s] = 1'b1; cls[s] = 2'(c); fa[s] = 6'(a); fb[s] = 3'(b);
        for (int n = 0; n < 16 && !acc; n++) begin
            @(negedge clk);
            acc = rdy[s];
            tick();
        end
        valid[s] = 1'b0;
        check(s, "accept", acc, 1);
    endtask

    task automatic log_check(input int s, input int idx, input int ea, input int ed);
        int e;
        if (s == 0) e = (idx < log_q0.size()) ? log_q0[idx] : -1;
        else        e = (idx < log_q1.size()) ? log_q1[idx] : -1;
        check(s, "log_addr", (e >> 8) & 255, ea);
        check(s, "log_data", e & 255, ed);
    endtask

    initial begin
        int dsum;
        rst = 1'b0; start = 2'b00; finish = 2'b00; valid = 2'b00; mem_rdy = 2'b00;
        for (int i = 0; i < 2; i++) begin cls[i] = 2'd0; fa[i] = 6'd0; fb[i] = 3'd0; end
        repeat (2) @(posedge clk);
        @(negedge clk);
        check(0, "rst_addr", waddr[0], 0);
        check(1, "rst_addr", waddr[1], 254);
        check(0, "rst_wen", wen[0], 0);
        check(0, "rst_busy", busy[0], 0);
        check(0, "rst_count", count[0], 0);
        rst = 1'b1;
        tick();

        // Four classes back to back with an always-ready memory
        mem_rdy[0] = 1'b1;
        pulse_start(0);
        send(0, 0, 6'h2A, 0); send(0, 1, 0, 4); send(0, 2, 3, 6); send(0, 3, 0, 5);
        tick(); tick();
        check(0, "s1_len", log_q0.size(), 4);
        log_check(0, 0, 0, 8'h2A); log_check(0, 1, 1, 8'h44);
        log_check(0, 2, 2, 8'h9E); log_check(0, 3, 3, 8'hC5);
        check(0, "s1_span", (log_q0[3] >> 16) - (log_q0[0] >> 16), 3);
        check(0, "s1_count", count[0], 4);

        // Backpressure: the pending byte must hold still
        log_q0.delete();
        mem_rdy[0] = 1'b0;
        send(0, 0, 6'h11, 0);
        valid[0] = 1'b1; cls[0] = 2'd0; fa[0] = 6'h12;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check(0, "bp_ready", rdy[0], 0);
            check(0, "bp_wen", wen[0], 1);
            check(0, "bp_addr", waddr[0], 4);
            check(0, "bp_data", wdata[0], 8'h11);
            tick();
        end
        mem_rdy[0] = 1'b1;
        send(0, 0, 6'h12, 0);
        tick(); tick();
        check(0, "bp_len", log_q0.size(), 2);
        log_check(0, 0, 4, 8'h11); log_check(0, 1, 5, 8'h12);

        // Illegal requests are swallowed and flagged
        log_q0.delete();
        pulse_start(0);
        check(0, "err_cleared", err[0], 0);
        send(0, 1, 0, 7);
        check(0, "err_set", err[0], 1);
        send(0, 2, 1, 7); send(0, 0, 1, 0);
        tick(); tick();
        check(0, "err_sticky", err[0], 1);
        check(0, "err_len", log_q0.size(), 1);
        log_check(0, 0, 0, 8'h01);
        check(0, "err_count", count[0], 1);

        // finish with a byte still waiting on the memory
        mem_rdy[0] = 1'b0;
        send(0, 0, 6'h33, 0);
        pulse_finish(0);
        @(negedge clk);
        check(0, "fin_done", done[0], 1);
        check(0, "fin_busy", busy[0], 0);
        check(0, "fin_wen", wen[0], 1);
        tick();
        check(0, "fin_done_once", done[0], 0);
        mem_rdy[0] = 1'b1;
        tick(); tick(); tick();
        check(0, "fin_wen_drop", wen[0], 0);
        check(0, "fin_count", count[0], 2);
        check(0, "fin_len", log_q0.size(), 2);
        log_check(0, 1, 1, 8'h33);

        // start and finish together restart rather than end the session
        pulse_start(0);
        send(0, 0, 6'h20, 0);
        start[0] = 1'b1; finish[0] = 1'b1; tick(); start[0] = 1'b0; finish[0] = 1'b0;
        @(negedge clk);
        check(0, "sf_count", count[0], 0);
        check(0, "sf_busy", busy[0], 1);
        check(0, "sf_done", done[0], 0);
        check(0, "sf_wen", wen[0], 0);
        pulse_finish(0);
        tick();

        // DEPTH=4 instance: fills, stops accepting, wraps its address
        mem_rdy[1] = 1'b1;
        pulse_start(1);
        for (int k = 1; k <= 4; k++) send(1, 0, k, 0);
        valid[1] = 1'b1; cls[1] = 2'd0; fa[1] = 6'd5;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check(1, "full_ready", rdy[1], 0);
            tick();
        end
        fa[1] = 6'd6;
        tick(); tick();
        valid[1] = 1'b0;
        check(1, "full_flag", full[1], 1);
        check(1, "full_count", count[1], 4);
        check(1, "full_len", log_q1.size(), 4);
        log_check(1, 0, 8'hFE, 8'h01); log_check(1, 1, 8'hFF, 8'h02);
        log_check(1, 2, 8'h00, 8'h03); log_check(1, 3, 8'h01, 8'h04);
        pulse_finish(1);
        dsum = 0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            dsum += int'(done[1]);
            tick();
        end
        check(1, "full_done_pulses", dsum, 1);
        check(1, "full_idle", busy[1], 0);

        // Asynchronous reset with a byte in flight
        mem_rdy[0] = 1'b1;
        pulse_start(0);
        send(0, 0, 6'h05, 0);
        tick();
        mem_rdy[0] = 1'b0;
        send(0, 0, 6'h06, 0);
        rst = 1'b0;
        #1;
        check(0, "ar_wen", wen[0], 0);
        check(0, "ar_addr", waddr[0], 0);
        check(0, "ar_data", wdata[0], 0);
        check(0, "ar_count", count[0], 0);
        check(0, "ar_busy", busy[0], 0);
        check(0, "ar_ready", rdy[0], 0);
        @(negedge clk);
        rst = 1'b1;
        tick();
        log_q0.delete();
        mem_rdy[0] = 1'b1;
        pulse_start(0);
        send(0, 0, 6'h07, 0);
        tick(); tick();
        check(0, "ar_len", log_q0.size(), 1);
        log_check(0, 0, 0, 8'h07);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
